// File: rtl/flash_ctrl_if.sv
// MCU-side request/response bus of the flash controller: valid/ready request, held response.
// master = bus decode side, slave = controller side.
interface flash_ctrl_if #(
  parameter int AW = 12
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout
  );
endinterface

// File: rtl/flash_ctrl.sv
// Flash word-array controller: strobe 1 cycle after accept, response CMD_GAP+2 cycles after accept
// when flash is idle; one op in flight, response held until rsp_ready, req_ready only in IDLE.
module flash_ctrl #(
  parameter int AW      = 12,
  parameter int DEPTH   = 1024,
  parameter int CMD_GAP = 3,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          nRST,
  flash_ctrl_if.slave   bus,
  output logic          fl_rd_en,
  output logic          fl_wr_en,
  output logic          fl_erase_en,
  output logic [AW-1:0] fl_addr,
  output logic [31:0]   fl_idata,
  input  logic [31:0]   fl_odata,
  input  logic          fl_busy,
  input  logic          fl_error
);

  localparam int CW = $clog2(CMD_GAP + TIMEOUT + 1);
  localparam int GW = $clog2(CMD_GAP + 1);
  localparam logic [CW-1:0] POLL_C   = CW'(CMD_GAP);
  localparam logic [CW-1:0] TMO_C    = CW'(CMD_GAP + TIMEOUT);
  localparam logic [GW-1:0] GAP_INIT = GW'(CMD_GAP);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {OP_RD = 2'b00, OP_WR = 2'b01, OP_ER = 2'b10, OP_ILL = 2'b11} op_e;

  state_e        state_q;
  op_e           op_q;
  logic [GW-1:0] gap_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_acc_q;
  logic          rd_en_q, wr_en_q, er_en_q;
  logic [AW-1:0] fl_addr_q;
  logic [31:0]   fl_idata_q;
  logic          rsp_valid_q, rsp_error_q, rsp_timeout_q;
  logic [31:0]   rsp_rdata_q;
  logic          req_ready;
  logic          req_bad;

  // Flash has no reset, so hold off new requests until a possibly in-flight op has drained.
  assign req_ready = (state_q == IDLE) && (gap_q == '0);
  assign req_bad   = (bus.req_op == OP_ILL) || ({1'b0, bus.req_addr} >= DEPTH_W);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q       <= IDLE;
      op_q          <= OP_RD;
      gap_q         <= GAP_INIT;
      cnt_q         <= '0;
      err_acc_q     <= 1'b0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      er_en_q       <= 1'b0;
      fl_addr_q     <= '0;
      fl_idata_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      er_en_q <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - GW'(1);

      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready) begin
            op_q          <= op_e'(bus.req_op);
            err_acc_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            if (req_bad) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
            end else begin
              // Strobe is registered here so it is high exactly during ISSUE.
              state_q     <= ISSUE;
              rsp_error_q <= 1'b0;
              fl_addr_q   <= bus.req_addr;
              fl_idata_q  <= bus.req_wdata;
              rd_en_q     <= (bus.req_op == OP_RD);
              wr_en_q     <= (bus.req_op == OP_WR);
              er_en_q     <= (bus.req_op == OP_ER);
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= CW'(1);
        end
        WAIT: begin
          err_acc_q <= err_acc_q | fl_error;
          if (cnt_q == CW'(1) && op_q == OP_RD) rsp_rdata_q <= fl_odata;
          // Busy is first polled on the CMD_GAP-th WAIT cycle, giving CMD_GAP+2 cycle latency.
          if (cnt_q >= POLL_C && !fl_busy) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= err_acc_q | fl_error;
          end else if (cnt_q >= TMO_C) begin
            state_q       <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign fl_rd_en        = rd_en_q;
  assign fl_wr_en        = wr_en_q;
  assign fl_erase_en     = er_en_q;
  assign fl_addr         = fl_addr_q;
  assign fl_idata        = fl_idata_q;

endmodule

// File: tb/tb_flash_ctrl.sv
// Bench for flash_ctrl: behavioural flash word array plus a scoreboard of expected responses.
module tb_flash_ctrl;
  localparam int AW      = 12;
  localparam int CMD_GAP = 3;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  flash_ctrl_if #(.AW(AW)) bus ();

  logic          fl_rd_en, fl_wr_en, fl_erase_en;
  logic [AW-1:0] fl_addr;
  logic [31:0]   fl_idata;
  logic [31:0]   fl_odata = '0;
  logic          fl_busy;
  logic          fl_error = 1'b0;

  flash_ctrl #(.AW(AW), .DEPTH(1024), .CMD_GAP(CMD_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .bus        (bus),
    .fl_rd_en   (fl_rd_en),
    .fl_wr_en   (fl_wr_en),
    .fl_erase_en(fl_erase_en),
    .fl_addr    (fl_addr),
    .fl_idata   (fl_idata),
    .fl_odata   (fl_odata),
    .fl_busy    (fl_busy),
    .fl_error   (fl_error)
  );

  // Flash model: read data next cycle, busy for busy_len cycles after a strobe,
  // error pulse on a write to a word that is not erased.
  logic [31:0] mem [0:1023];
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_dat = '0;
  logic        force_busy = 1'b0;
  int          busy_len = 2;
  int          busy_cnt = 0;

  always @(posedge clk) begin
    fl_error <= 1'b0;
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (load_en) mem[load_addr] <= load_dat;
    if (fl_rd_en) begin
      fl_odata <= mem[fl_addr[9:0]];
      busy_cnt <= busy_len;
    end
    if (fl_wr_en) begin
      if (mem[fl_addr[9:0]] != 32'hFFFF_FFFF) fl_error <= 1'b1;
      else mem[fl_addr[9:0]] <= fl_idata;
      busy_cnt <= busy_len;
    end
    if (fl_erase_en) begin
      mem[fl_addr[9:0]] <= 32'hFFFF_FFFF;
      busy_cnt <= busy_len;
    end
  end
  assign fl_busy = force_busy | (busy_cnt != 0);

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
    int          kind;   // 0 none, 1 read, 2 write, 3 erase strobe
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_dat = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string w);
    check_val({w, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check_val({w, "_rsp_rdata"}, bus.rsp_rdata, 0);
    check_val({w, "_rsp_err"}, {30'd0, bus.rsp_error, bus.rsp_timeout}, 0);
    check_val({w, "_strobes"}, {29'd0, fl_rd_en, fl_wr_en, fl_erase_en}, 0);
    check_val({w, "_fl_addr"}, 32'(fl_addr), 0);
    check_val({w, "_fl_idata"}, fl_idata, 0);
    check_val({w, "_req_ready"}, 32'(bus.req_ready), 0);
  endtask

  // Guard: cycles with nRST high and req_ready low; called in the cycle nRST is released.
  task automatic check_guard(input string w);
    int n;
    nRST = 1'b1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.req_ready) break;
      n++;
    end
    check_val({w, "_guard"}, 32'(n), 32'(CMD_GAP));
  endtask

  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [31:0] e_rd, input logic e_err, input logic e_tmo,
                        input int e_lat, input int e_kind, input int hold, input string tag);
    exp_t e, g;
    int k, ns, kind, sk;
    e.rdata = e_rd; e.err = e_err; e.tmo = e_tmo; e.lat = e_lat; e.kind = e_kind;
    sb.push_back(e);
    bus.rsp_ready = (hold == 0);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
    k = 0;
    while (!bus.req_ready && k < 100) begin step(); k++; end
    if (!bus.req_ready) begin
      check_val({tag, "_accept_timeout"}, 0, 1);
      bus.req_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    step();
    bus.req_valid = 1'b0;
    k = 1; ns = 0; kind = 0; sk = -1;
    while (!bus.rsp_valid && k < 200) begin
      ns += int'(fl_rd_en) + int'(fl_wr_en) + int'(fl_erase_en);
      if (fl_rd_en)    begin kind = 1; sk = k; end
      if (fl_wr_en)    begin kind = 2; sk = k; end
      if (fl_erase_en) begin kind = 3; sk = k; end
      step();
      k++;
    end
    if (!bus.rsp_valid) begin
      check_val({tag, "_rsp_timeout"}, 0, 1);
      void'(sb.pop_front());
      bus.rsp_ready = 1'b1;
      return;
    end
    g = sb.pop_front();
    check_val({tag, "_latency"}, 32'(k), 32'(g.lat));
    check_val({tag, "_rdata"}, bus.rsp_rdata, g.rdata);
    check_val({tag, "_error"}, 32'(bus.rsp_error), 32'(g.err));
    check_val({tag, "_timeout"}, 32'(bus.rsp_timeout), 32'(g.tmo));
    check_val({tag, "_nstrobe"}, 32'(ns), 32'(g.kind != 0));
    if (g.kind != 0) begin
      check_val({tag, "_strobe_kind"}, 32'(kind), 32'(g.kind));
      check_val({tag, "_strobe_cycle"}, 32'(sk), 1);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      check_val({tag, "_hold_valid"}, 32'(bus.rsp_valid), 1);
      check_val({tag, "_hold_rdata"}, bus.rsp_rdata, g.rdata);
      check_val({tag, "_hold_req_ready"}, 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    check_val({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 0);
    check_val({tag, "_req_ready_rise"}, 32'(bus.req_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic saw;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    check_reset_vals("por");
    check_guard("por");

    load(10'd5, 32'hDEAD_BEEF);
    load(10'd7, 32'h0BAD_F00D);
    load(10'd9, 32'h0000_0000);
    load(10'd1023, 32'hA5A5_0001);

    //      op     addr     wdata          rdata         err   tmo  lat kind hold
    do_req(2'b00, 12'd5,    32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 5, 1, 0, "read5");
    do_req(2'b10, 12'd7,    32'h0,         32'h0,         1'b0, 1'b0, 5, 3, 0, "erase7");
    do_req(2'b01, 12'd7,    32'h1234_5678, 32'h0,         1'b0, 1'b0, 5, 2, 0, "write7");
    do_req(2'b00, 12'd7,    32'h0,         32'h1234_5678, 1'b0, 1'b0, 5, 1, 0, "read7");
    do_req(2'b01, 12'd9,    32'hCAFE_0000, 32'h0,         1'b1, 1'b0, 5, 2, 0, "write_dirty");
    do_req(2'b00, 12'd1023, 32'h0,         32'hA5A5_0001, 1'b0, 1'b0, 5, 1, 0, "read_last");
    do_req(2'b00, 12'd1024, 32'h0,         32'h0,         1'b1, 1'b0, 1, 0, 0, "range");
    do_req(2'b11, 12'd3,    32'h0,         32'h0,         1'b1, 1'b0, 1, 0, 0, "illegal");

    busy_len = 5;
    do_req(2'b00, 12'd5,    32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 8, 1, 0, "read_slow");
    busy_len = 2;

    force_busy = 1'b1;
    do_req(2'b10, 12'd20,   32'h0,         32'h0,         1'b1, 1'b1, CMD_GAP + TIMEOUT + 2, 3, 0,
           "timeout");
    force_busy = 1'b0;

    do_req(2'b00, 12'd5,    32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 5, 1, 10, "backpressure");

    // Reset while in WAIT: the op is abandoned and no response may appear.
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_addr = 12'd5;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    nRST = 1'b0;
    step();
    check_reset_vals("midop");
    check_guard("midop");
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw = saw | bus.rsp_valid | fl_rd_en | fl_wr_en | fl_erase_en;
      step();
    end
    check_val("midop_no_rsp", 32'(saw), 0);

    do_req(2'b00, 12'd7,    32'h0,         32'h1234_5678, 1'b0, 1'b0, 5, 1, 0, "recover");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
